// File: rtl/avl_bus_arbiter.sv
// avl_bus_arbiter
//
// Shares one Avalon-style slave port among MASTER_NUM masters. At most one
// command (read or write) is granted per cycle. The master index of every
// accepted read is pushed into an in-order routing FIFO, and the FIFO head
// steers each slave read response back to the master that issued it.
//
// Optional feature macro: AVL_ARB_ROUND_ROBIN_EN
//   defined   : round-robin arbitration from a registered priority pointer
//   undefined : fixed priority, lowest master index wins
//
// Ports:
//   clk, rest            bus clock, synchronous active-high reset
//   m_read, m_write      per-master command requests
//   m_address, m_byte_en, m_write_data   per-master command fields
//   m_request_ready      per-master command accept (one-hot or zero)
//   m_read_data          slave read data broadcast to every master
//   m_read_data_valid    per-master response valid (one-hot or zero)
//   m_resp_ready         per-master response ready
//   s_read, s_write, s_address, s_byte_en, s_write_data   slave command bus
//   s_request_ready      slave accepts the presented command
//   s_read_data, s_read_data_valid, s_resp_ready          slave response
//   outstanding          number of reads currently in flight
//   err_unexpected_resp  sticky: response arrived with no read in flight

module avl_bus_arbiter #(
  parameter int MASTER_NUM      = 8,
  parameter int RESP_FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rest,
  input  logic [MASTER_NUM-1:0]               m_read,
  input  logic [MASTER_NUM-1:0]               m_write,
  input  logic [MASTER_NUM-1:0][31:0]         m_address,
  input  logic [MASTER_NUM-1:0][3:0]          m_byte_en,
  input  logic [MASTER_NUM-1:0][31:0]         m_write_data,
  output logic [MASTER_NUM-1:0]               m_request_ready,
  output logic [MASTER_NUM-1:0][31:0]         m_read_data,
  output logic [MASTER_NUM-1:0]               m_read_data_valid,
  input  logic [MASTER_NUM-1:0]               m_resp_ready,
  output logic                                s_read,
  output logic                                s_write,
  output logic [31:0]                         s_address,
  output logic [3:0]                          s_byte_en,
  output logic [31:0]                         s_write_data,
  input  logic                                s_request_ready,
  input  logic [31:0]                         s_read_data,
  input  logic                                s_read_data_valid,
  output logic                                s_resp_ready,
  output logic [$clog2(RESP_FIFO_DEPTH):0]    outstanding,
  output logic                                err_unexpected_resp
);

  localparam int IDX_W = $clog2(MASTER_NUM);
  localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [MASTER_NUM-1:0] eligible;
  logic                  win_valid;
  logic [IDX_W-1:0]      win_idx;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [IDX_W-1:0]      head_idx;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [IDX_W-1:0]      fifo_mem [RESP_FIFO_DEPTH];

  assign fifo_empty = (outstanding == '0);
  assign fifo_full  = (outstanding == CNT_W'(RESP_FIFO_DEPTH));
  assign head_idx   = fifo_mem[rd_ptr];

  // A master that raises read (even together with write) is issuing a read,
  // so it must wait while the FIFO is full; there is no pop bypass.
  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      eligible[i] = m_read[i] ? !fifo_full : m_write[i];
    end
  end

`ifdef AVL_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_cand;
  int               rr_sum;

  // Scan masters starting at the priority pointer, wrapping at MASTER_NUM.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    rr_sum    = 0;
    rr_cand   = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      rr_sum = int'(rr_ptr) + k;
      if (rr_sum >= MASTER_NUM) begin
        rr_sum = rr_sum - MASTER_NUM;
      end
      rr_cand = rr_sum[IDX_W-1:0];
      if (!win_valid && eligible[rr_cand]) begin
        win_valid = 1'b1;
        win_idx   = rr_cand;
      end
    end
  end

  // The pointer only moves on an accepted command, so a stalled grant keeps
  // its place in the rotation.
  always_ff @(posedge clk) begin
    if (rest) begin
      rr_ptr <= '0;
    end else if (s_request_ready && win_valid) begin
      rr_ptr <= (win_idx == IDX_W'(MASTER_NUM - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      if (!win_valid && eligible[k]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end
`endif

  // Winner's fields drive the slave command bus; idle bus is all zero.
  always_comb begin
    s_read          = win_valid & m_read[win_idx];
    s_write         = win_valid & ~m_read[win_idx] & m_write[win_idx];
    s_address       = win_valid ? m_address[win_idx]    : '0;
    s_byte_en       = win_valid ? m_byte_en[win_idx]    : '0;
    s_write_data    = win_valid ? m_write_data[win_idx] : '0;
    m_request_ready = '0;
    if (win_valid && s_request_ready) begin
      m_request_ready[win_idx] = 1'b1;
    end
  end

  assign push = s_request_ready & s_read;

  // Responses follow the FIFO head; with nothing in flight the stray
  // response is drained and reaches no master.
  always_comb begin
    m_read_data_valid = '0;
    s_resp_ready      = 1'b1;
    if (!fifo_empty) begin
      m_read_data_valid[head_idx] = s_read_data_valid;
      s_resp_ready                = m_resp_ready[head_idx];
    end
    for (int i = 0; i < MASTER_NUM; i++) begin
      m_read_data[i] = s_read_data;
    end
  end

  assign pop = s_read_data_valid & s_resp_ready & !fifo_empty;

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= win_idx;
    end
  end

  // Pointers, occupancy and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rest) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      outstanding         <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (s_read_data_valid && fifo_empty) begin
        err_unexpected_resp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// tb_avl_bus_arbiter
//
// Self-checking bench for avl_bus_arbiter. Two instances share stimulus:
// dut (RESP_FIFO_DEPTH=8) and dut2 (RESP_FIFO_DEPTH=2, used for the
// full-FIFO sequence). A table of single-cycle vectors covers arbitration
// and routing; hand-written sequences cover the multi-cycle cases.
// Expected grants differ with AVL_ARB_ROUND_ROBIN_EN, so the table carries
// both a round-robin and a fixed-priority expectation.

module tb_avl_bus_arbiter;

  localparam int MN = 8;

  logic                clk;
  logic                rest;
  logic [MN-1:0]       m_read;
  logic [MN-1:0]       m_write;
  logic [MN-1:0][31:0] m_address;
  logic [MN-1:0][3:0]  m_byte_en;
  logic [MN-1:0][31:0] m_write_data;
  logic [MN-1:0]       m_resp_ready;
  logic                s_request_ready;
  logic [31:0]         s_read_data;
  logic                s_read_data_valid;

  logic [MN-1:0]       m_request_ready;
  logic [MN-1:0][31:0] m_read_data;
  logic [MN-1:0]       m_read_data_valid;
  logic                s_read;
  logic                s_write;
  logic [31:0]         s_address;
  logic [3:0]          s_byte_en;
  logic [31:0]         s_write_data;
  logic                s_resp_ready;
  logic [3:0]          outstanding;
  logic                err_unexpected_resp;

  logic [MN-1:0]       d2_m_request_ready;
  logic [MN-1:0][31:0] d2_m_read_data;
  logic [MN-1:0]       d2_m_read_data_valid;
  logic                d2_s_read;
  logic                d2_s_write;
  logic [31:0]         d2_s_address;
  logic [3:0]          d2_s_byte_en;
  logic [31:0]         d2_s_write_data;
  logic                d2_s_resp_ready;
  logic [1:0]          d2_outstanding;
  logic                d2_err_unexpected_resp;

  int n_tests = 0;
  int n_fail  = 0;

  avl_bus_arbiter #(.MASTER_NUM(MN), .RESP_FIFO_DEPTH(8)) dut (
    .clk(clk), .rest(rest),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_byte_en(m_byte_en), .m_write_data(m_write_data),
    .m_request_ready(m_request_ready), .m_read_data(m_read_data),
    .m_read_data_valid(m_read_data_valid), .m_resp_ready(m_resp_ready),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_byte_en(s_byte_en), .s_write_data(s_write_data),
    .s_request_ready(s_request_ready), .s_read_data(s_read_data),
    .s_read_data_valid(s_read_data_valid), .s_resp_ready(s_resp_ready),
    .outstanding(outstanding), .err_unexpected_resp(err_unexpected_resp)
  );

  avl_bus_arbiter #(.MASTER_NUM(MN), .RESP_FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rest(rest),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_byte_en(m_byte_en), .m_write_data(m_write_data),
    .m_request_ready(d2_m_request_ready), .m_read_data(d2_m_read_data),
    .m_read_data_valid(d2_m_read_data_valid), .m_resp_ready(m_resp_ready),
    .s_read(d2_s_read), .s_write(d2_s_write), .s_address(d2_s_address),
    .s_byte_en(d2_s_byte_en), .s_write_data(d2_s_write_data),
    .s_request_ready(s_request_ready), .s_read_data(s_read_data),
    .s_read_data_valid(s_read_data_valid), .s_resp_ready(d2_s_resp_ready),
    .outstanding(d2_outstanding), .err_unexpected_resp(d2_err_unexpected_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rd;
    logic [7:0]  wr;
    logic        srr;
    logic        srdv;
    logic [31:0] srdata;
    logic [7:0]  mresp;
    int          win_rr;
    int          win_fp;
    logic [7:0]  mrdv_rr;
    logic [7:0]  mrdv_fp;
    logic        sresp;
    logic [3:0]  outst;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mkv(logic [7:0] rd, logic [7:0] wr, logic srr,
                               logic srdv, logic [31:0] srdata,
                               logic [7:0] mresp, int wrr, int wfp,
                               logic [7:0] drr, logic [7:0] dfp,
                               logic sresp, logic [3:0] outst);
    vec_t v;
    v.rd = rd; v.wr = wr; v.srr = srr; v.srdv = srdv; v.srdata = srdata;
    v.mresp = mresp; v.win_rr = wrr; v.win_fp = wfp; v.mrdv_rr = drr;
    v.mrdv_fp = dfp; v.sresp = sresp; v.outst = outst;
    return v;
  endfunction

  // Comparison primitive shared by table and hand sequences.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Distinct per-master command fields so the mux selection is visible.
  task automatic setDefaults();
    for (int i = 0; i < MN; i++) begin
      m_address[i]    = 32'h1000 + (i << 8);
      m_byte_en[i]    = 4'(i);
      m_write_data[i] = 32'hD000_0000 + i;
    end
    m_read            = '0;
    m_write           = '0;
    m_resp_ready      = '1;
    s_request_ready   = 1'b1;
    s_read_data       = '0;
    s_read_data_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    m_read            = v.rd;
    m_write           = v.wr;
    s_request_ready   = v.srr;
    s_read_data_valid = v.srdv;
    s_read_data       = v.srdata;
    m_resp_ready      = v.mresp;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    setDefaults();
    rest = 1'b1;
    nextCycle();
    nextCycle();
    rest = 1'b0;
  endtask

  initial begin
    int w;
    logic [7:0] exp_mrdv;
    logic [7:0] exp_mrr;

    tbl[0]  = mkv(8'h00, 8'h00, 1, 0, 32'h0,    8'hFF, -1, -1, 8'h00, 8'h00, 1, 4'd0);
    tbl[1]  = mkv(8'h00, 8'h29, 0, 0, 32'h0,    8'hFF,  0,  0, 8'h00, 8'h00, 1, 4'd0);
    tbl[2]  = mkv(8'h00, 8'h29, 1, 0, 32'h0,    8'hFF,  0,  0, 8'h00, 8'h00, 1, 4'd0);
    tbl[3]  = mkv(8'h00, 8'h29, 1, 0, 32'h0,    8'hFF,  3,  0, 8'h00, 8'h00, 1, 4'd0);
    tbl[4]  = mkv(8'h00, 8'h29, 1, 0, 32'h0,    8'hFF,  5,  0, 8'h00, 8'h00, 1, 4'd0);
    tbl[5]  = mkv(8'h00, 8'h29, 1, 0, 32'h0,    8'hFF,  0,  0, 8'h00, 8'h00, 1, 4'd0);
    tbl[6]  = mkv(8'h00, 8'h29, 1, 0, 32'h0,    8'hFF,  3,  0, 8'h00, 8'h00, 1, 4'd0);
    tbl[7]  = mkv(8'h00, 8'h29, 1, 0, 32'h0,    8'hFF,  5,  0, 8'h00, 8'h00, 1, 4'd0);
    tbl[8]  = mkv(8'h82, 8'h00, 1, 0, 32'h0,    8'hFF,  7,  1, 8'h00, 8'h00, 1, 4'd0);
    tbl[9]  = mkv(8'h00, 8'h00, 1, 1, 32'h1234, 8'hFF, -1, -1, 8'h80, 8'h02, 1, 4'd1);
    tbl[10] = mkv(8'h10, 8'h04, 1, 0, 32'h0,    8'hFF,  2,  2, 8'h00, 8'h00, 1, 4'd0);
    tbl[11] = mkv(8'h10, 8'h00, 1, 0, 32'h0,    8'hFF,  4,  4, 8'h00, 8'h00, 1, 4'd0);
    tbl[12] = mkv(8'h00, 8'h00, 1, 1, 32'h5555, 8'h00, -1, -1, 8'h10, 8'h10, 0, 4'd1);
    tbl[13] = mkv(8'h00, 8'h00, 1, 1, 32'h6666, 8'h10, -1, -1, 8'h10, 8'h10, 1, 4'd1);
    tbl[14] = mkv(8'h00, 8'h00, 1, 0, 32'h0,    8'hFF, -1, -1, 8'h00, 8'h00, 1, 4'd0);
    tbl[15] = mkv(8'h08, 8'h08, 1, 0, 32'h0,    8'hFF,  3,  3, 8'h00, 8'h00, 1, 4'd0);
    tbl[16] = mkv(8'h00, 8'h00, 1, 1, 32'h7777, 8'hFF, -1, -1, 8'h08, 8'h08, 1, 4'd1);
    tbl[17] = mkv(8'h00, 8'h00, 1, 0, 32'h0,    8'hFF, -1, -1, 8'h00, 8'h00, 1, 4'd0);

    $display("[TB] start");
    setDefaults();
    rest = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("reset outstanding", 32'(outstanding), 32'd0);
    checkOutput("reset err", 32'(err_unexpected_resp), 32'd0);
    checkOutput("reset s_resp_ready", 32'(s_resp_ready), 32'd1);
    checkOutput("reset m_read_data_valid", 32'(m_read_data_valid), 32'd0);
    checkOutput("reset s_read", 32'(s_read), 32'd0);
    doReset();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 18; i++) begin
`ifdef AVL_ARB_ROUND_ROBIN_EN
      w        = tbl[i].win_rr;
      exp_mrdv = tbl[i].mrdv_rr;
`else
      w        = tbl[i].win_fp;
      exp_mrdv = tbl[i].mrdv_fp;
`endif
      exp_mrr = '0;
      if (w >= 0 && tbl[i].srr) exp_mrr[w] = 1'b1;
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d m_request_ready", i), 32'(m_request_ready), 32'(exp_mrr));
      checkOutput($sformatf("vec%0d s_read", i), 32'(s_read),
                  32'((w >= 0) && tbl[i].rd[w]));
      checkOutput($sformatf("vec%0d s_write", i), 32'(s_write),
                  32'((w >= 0) && !tbl[i].rd[w] && tbl[i].wr[w]));
      checkOutput($sformatf("vec%0d s_address", i), s_address,
                  (w >= 0) ? 32'h1000 + (w << 8) : 32'h0);
      checkOutput($sformatf("vec%0d s_byte_en", i), 32'(s_byte_en),
                  (w >= 0) ? 32'(w % 16) : 32'h0);
      checkOutput($sformatf("vec%0d s_write_data", i), s_write_data,
                  (w >= 0) ? 32'hD000_0000 + w : 32'h0);
      checkOutput($sformatf("vec%0d m_read_data_valid", i), 32'(m_read_data_valid), 32'(exp_mrdv));
      checkOutput($sformatf("vec%0d s_resp_ready", i), 32'(s_resp_ready), 32'(tbl[i].sresp));
      checkOutput($sformatf("vec%0d outstanding", i), 32'(outstanding), 32'(tbl[i].outst));
      checkOutput($sformatf("vec%0d err", i), 32'(err_unexpected_resp), 32'd0);
      if (tbl[i].srdv) begin
        checkOutput($sformatf("vec%0d m_read_data", i), m_read_data[7], tbl[i].srdata);
      end
      nextCycle();
    end

    // ---------------- in-order read routing ----------------
    doReset();
    m_address[2] = 32'h100;
    m_address[6] = 32'h200;
    m_read = 8'h04;
    @(negedge clk);
    checkOutput("route outstanding0", 32'(outstanding), 32'd0);
    checkOutput("route grant m2", 32'(m_request_ready), 32'h04);
    checkOutput("route addr m2", s_address, 32'h100);
    nextCycle();
    m_read = 8'h40;
    @(negedge clk);
    checkOutput("route outstanding1", 32'(outstanding), 32'd1);
    checkOutput("route addr m6", s_address, 32'h200);
    nextCycle();
    m_read = 8'h00;
    s_read_data_valid = 1'b1;
    s_read_data = 32'hAAAA;
    @(negedge clk);
    checkOutput("route outstanding2", 32'(outstanding), 32'd2);
    checkOutput("route valid m2", 32'(m_read_data_valid), 32'h04);
    checkOutput("route data m2", m_read_data[2], 32'hAAAA);
    nextCycle();
    s_read_data = 32'hBBBB;
    @(negedge clk);
    checkOutput("route outstanding3", 32'(outstanding), 32'd1);
    checkOutput("route valid m6", 32'(m_read_data_valid), 32'h40);
    checkOutput("route data m6", m_read_data[6], 32'hBBBB);
    nextCycle();
    s_read_data_valid = 1'b0;
    @(negedge clk);
    checkOutput("route outstanding4", 32'(outstanding), 32'd0);
    checkOutput("route err", 32'(err_unexpected_resp), 32'd0);

    // ---------------- full FIFO on the depth-2 instance ----------------
    doReset();
    m_read = 8'h02;
    nextCycle();
    m_read = 8'h04;
    nextCycle();
    m_read = 8'h08;
    m_write = 8'h10;
    @(negedge clk);
    checkOutput("full outstanding", 32'(d2_outstanding), 32'd2);
    checkOutput("full write granted", 32'(d2_m_request_ready), 32'h10);
    checkOutput("full s_write", 32'(d2_s_write), 32'd1);
    nextCycle();
    m_write = 8'h00;
    s_read_data_valid = 1'b1;
    s_read_data = 32'h1111;
    @(negedge clk);
    checkOutput("full read held", 32'(d2_m_request_ready), 32'h00);
    checkOutput("full s_read idle", 32'(d2_s_read), 32'd0);
    checkOutput("full resp to m1", 32'(d2_m_read_data_valid), 32'h02);
    nextCycle();
    s_read_data_valid = 1'b0;
    @(negedge clk);
    checkOutput("full after pop outstanding", 32'(d2_outstanding), 32'd1);
    checkOutput("full third read granted", 32'(d2_m_request_ready), 32'h08);
    checkOutput("full third s_read", 32'(d2_s_read), 32'd1);

    // ---------------- response backpressure ----------------
    doReset();
    m_read = 8'h20;
    nextCycle();
    m_read = 8'h00;
    m_resp_ready = 8'h00;
    s_read_data_valid = 1'b1;
    s_read_data = 32'hCAFE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d s_resp_ready", c), 32'(s_resp_ready), 32'd0);
      checkOutput($sformatf("hold%0d outstanding", c), 32'(outstanding), 32'd1);
      checkOutput($sformatf("hold%0d valid", c), 32'(m_read_data_valid), 32'h20);
      nextCycle();
    end
    m_resp_ready = 8'h20;
    @(negedge clk);
    checkOutput("hold release s_resp_ready", 32'(s_resp_ready), 32'd1);
    nextCycle();
    s_read_data_valid = 1'b0;
    @(negedge clk);
    checkOutput("hold single pop", 32'(outstanding), 32'd0);
    checkOutput("hold no error", 32'(err_unexpected_resp), 32'd0);

    // ---------------- unexpected response ----------------
    doReset();
    s_read_data_valid = 1'b1;
    @(negedge clk);
    checkOutput("stray err before edge", 32'(err_unexpected_resp), 32'd0);
    checkOutput("stray drained", 32'(s_resp_ready), 32'd1);
    checkOutput("stray no valid", 32'(m_read_data_valid), 32'h00);
    nextCycle();
    s_read_data_valid = 1'b0;
    @(negedge clk);
    checkOutput("stray err set", 32'(err_unexpected_resp), 32'd1);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("stray err sticky", 32'(err_unexpected_resp), 32'd1);
    rest = 1'b1;
    nextCycle();
    rest = 1'b0;
    @(negedge clk);
    checkOutput("stray err cleared", 32'(err_unexpected_resp), 32'd0);

    // ---------------- reset with reads in flight ----------------
    doReset();
    m_read = 8'h01;
    nextCycle();
    m_read = 8'h02;
    nextCycle();
    m_read = 8'h04;
    nextCycle();
    m_read = 8'h00;
    @(negedge clk);
    checkOutput("midreset outstanding3", 32'(outstanding), 32'd3);
    rest = 1'b1;
    nextCycle();
    rest = 1'b0;
    @(negedge clk);
    checkOutput("midreset outstanding0", 32'(outstanding), 32'd0);
    s_read_data_valid = 1'b1;
    @(negedge clk);
    checkOutput("midreset resp no valid", 32'(m_read_data_valid), 32'h00);
    nextCycle();
    s_read_data_valid = 1'b0;
    @(negedge clk);
    checkOutput("midreset err set", 32'(err_unexpected_resp), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avl_bus_arbiter.md
# avl_bus_arbiter

Shares one Avalon-style slave port among `MASTER_NUM` masters on the system bus. Each cycle it grants at most one master command (read or write) to the slave and records the issuing master of every accepted read in an in-order routing FIFO. Read responses are routed back to the correct master in issue order. It sits between the master-side `i_avl_bus` ports and a single slave, upstream of the bus monitor, and must never issue more than one command per cycle.

## Interface
- `MASTER_NUM`, 8, number of master ports (2..16)
- `RESP_FIFO_DEPTH`, 8, outstanding-read capacity, power of two (2..64)
- `clk`  in  1  bus clock
- `rest`  in  1  reset; synchronous, active-high
- `m_read`  in  `[MASTER_NUM-1:0]`  per-master read request
- `m_write`  in  `[MASTER_NUM-1:0]`  per-master write request
- `m_address`  in  `[MASTER_NUM-1:0][31:0]`  per-master byte address
- `m_byte_en`  in  `[MASTER_NUM-1:0][3:0]`  per-master byte enables
- `m_write_data`  in  `[MASTER_NUM-1:0][31:0]`  per-master write data
- `m_request_ready`  out  `[MASTER_NUM-1:0]`  command accepted, one-hot or zero
- `m_read_data`  out  `[MASTER_NUM-1:0][31:0]`  read data; slave data broadcast to all masters
- `m_read_data_valid`  out  `[MASTER_NUM-1:0]`  response valid, one-hot or zero
- `m_resp_ready`  in  `[MASTER_NUM-1:0]`  master can take a response
- `s_read`, `s_write`  out  1  slave command strobes
- `s_address`  out  32  slave address
- `s_byte_en`  out  4  slave byte enables
- `s_write_data`  out  32  slave write data
- `s_request_ready`  in  1  slave accepts command
- `s_read_data`  in  32  slave read data
- `s_read_data_valid`  in  1  slave response valid
- `s_resp_ready`  out  1  response consumed
- `outstanding`  out  `$clog2(RESP_FIFO_DEPTH)+1`  reads in flight
- `err_unexpected_resp`  out  1  sticky error flag

## Operation
- A master is eligible when `m_read|m_write`, except that read requests are ineligible while `outstanding==RESP_FIFO_DEPTH`. A master asserting both `read` and `write` is a protocol violation; read takes priority.
- The winner is chosen combinationally among eligible masters. The winner's fields drive the `s_*` command bus. If there is no winner, `s_read=s_write=0` and the `s_*` data fields are 0.
- `m_request_ready[w] = s_request_ready & winner valid`; all other bits are 0.
- An accepted command is one with `s_request_ready` high while `s_read` or `s_write` is high.
- Routing FIFO:
  - Push the winner index on every accepted read.
  - Pop on `s_read_data_valid & s_resp_ready`.
  - Push and pop in the same cycle leave `outstanding` unchanged.
  - Read and write pointers wrap modulo `RESP_FIFO_DEPTH`.
- Response routing:
  - `h` = FIFO head. `m_read_data_valid[h] = s_read_data_valid`.
  - `s_resp_ready = m_resp_ready[h]`.
  - If the FIFO is empty, `m_read_data_valid=0` and `s_resp_ready=1`, so the stray response is drained.
- If `s_read_data_valid` is asserted while the FIFO is empty, `err_unexpected_resp` is set and stays set until `rest`.
- Writes carry no response and never touch the FIFO.
- Reset values while `rest` is high:
  - FIFO is emptied, `outstanding=0`, `err_unexpected_resp=0`, priority pointer = 0.
  - Combinational outputs follow from the emptied state.
  - In-flight reads are discarded; later slave responses count as unexpected.

## Timing
- Command path: zero-cycle latency; fully combinational from `m_*` and `s_request_ready` to `s_*` and `m_request_ready`.
- Response path: zero-cycle latency; combinational from the registered FIFO head.
- `outstanding`, the FIFO and the priority pointer update on the rising `clk` edge after an accept or pop.
- A read accepted in cycle N can receive its response in cycle N+1 at the earliest, because the head is registered.
- A full FIFO blocks new read grants, even when a pop happens in the same cycle; there is no bypass. Writes can still be granted while the FIFO is full.
- A master holds its request until `m_request_ready`. The arbiter may switch grants between cycles while the slave stalls.

## Configuration
- `AVL_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration starting at the priority pointer.
  - After each accepted command, the pointer becomes `(winner+1) % MASTER_NUM`.
  - A stalled grant (no accept) does not move the pointer.
- Not defined: fixed priority, lowest index wins. The pointer logic is absent.

## Test plan
- With `AVL_ARB_ROUND_ROBIN_EN` defined, masters 0, 3 and 5 request writes every cycle with `s_request_ready=1`. Required: grants go 0,3,5,0,3,5 and exactly one `m_request_ready` bit is set per cycle.
- Without the macro, the same stimulus gives master 0 every grant.
- Master 2 reads 0x100, then master 6 reads 0x200. The slave returns 0xAAAA then 0xBBBB. Required: `m_read_data_valid[2]` with 0xAAAA, then `m_read_data_valid[6]` with 0xBBBB, and `outstanding` goes 0→1→2→1→0.
- `RESP_FIFO_DEPTH=2`, no slave responses. Required:
  - A third read is held off (`m_request_ready=0`).
  - A concurrent write from another master is granted.
  - After one response, the third read is granted the next cycle.
- Response at the head with `m_resp_ready[h]=0` for 3 cycles. Required: `s_resp_ready=0` and no pop for those 3 cycles, then a single pop.
- `s_read_data_valid=1` with the FIFO empty. Required: `err_unexpected_resp=1` from the next cycle, cleared only by `rest`.
- Reset mid-operation: assert `rest` with 3 reads outstanding. Required: `outstanding=0` the next cycle, and the next slave response sets the error flag.
